// File: rtl/tpp_pkg.sv
// Shared definitions for the table-driven PWM player: FSM state encoding
// and helpers for widths that depend on the player's parameters.
package tpp_pkg;

    // Playback sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CAPT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    // Largest PWM counter value for a given sample width: (1 << width) - 1
    function automatic int unsigned pwm_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage : tpp_pkg

// File: rtl/pwm_prescaler.sv
// Tick generator for the PWM counter: one tick every prescale+1 clocks.
// The count compares with >= so that lowering prescale mid-count issues
// a tick immediately instead of waiting for a full counter wrap.
module pwm_prescaler #(
    parameter int unsigned div_width = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 En,
    input  logic [div_width-1:0] prescale,
    output logic                 tick
);

    logic [div_width-1:0] pre_cnt_q;
    logic [div_width-1:0] pre_cnt_d;

    // Tick decode and next count: clear on tick or when disabled
    always_comb begin
        tick      = En && (pre_cnt_q >= prescale);
        pre_cnt_d = pre_cnt_q + 1'b1;
        if (!En || tick) begin
            pre_cnt_d = '0;
        end
    end

    // Prescale counter register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule : pwm_prescaler

// File: rtl/table_pwm_player.sv
// Plays samples from a synchronous signal-table RAM as PWM duty cycles,
// one sample per PWM period, wrapping after table_len samples. The next
// sample is prefetched (FETCH/CAPT) right after each load so it is ready
// long before the current period ends.
module table_pwm_player
    import tpp_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 7,
    parameter int unsigned table_len  = 100,
    parameter int unsigned div_width  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  En,
    input  logic [div_width-1:0]  prescale,
    output logic [addr_width-1:0] table_addr,
    output logic                  table_wr,
    input  logic [data_width-1:0] table_data,
    output logic                  pwm_out,
    output logic [data_width-1:0] duty,
    output logic                  sample_strobe,
    output logic                  wrap
);

    localparam logic [data_width-1:0] PWM_MAX  = data_width'(pwm_max(data_width));
    localparam logic [addr_width-1:0] LAST_IDX = addr_width'(table_len - 1);

    // With data_width=1 and prescale=0 a period is only two clocks, which
    // leaves the two-clock prefetch no margin at all.
    if (data_width < 2) begin : g_chk_data_width
        $error("table_pwm_player: data_width must be at least 2");
    end
    if (table_len < 1 || table_len > (32'd1 << addr_width)) begin : g_chk_table_len
        $error("table_pwm_player: table_len must be in 1..2^addr_width");
    end

    state_e                state_q,      state_d;
    logic [addr_width-1:0] idx_q,        idx_d;
    logic [addr_width-1:0] idx_nxt;
    logic [addr_width-1:0] table_addr_q, table_addr_d;
    logic [data_width-1:0] next_duty_q,  next_duty_d;
    logic [data_width-1:0] duty_q,       duty_d;
    logic [data_width-1:0] pwm_cnt_q,    pwm_cnt_d;
    logic                  running_q,    running_d;
    logic                  pwm_out_q,    pwm_out_d;
    logic                  strobe_q,     strobe_d;
    logic                  wrap_q,       wrap_d;
    logic                  do_load;
    logic                  period_end;
    logic                  tick;

    // Ticks only run once a sample is playing, so the first period after
    // enable has the same length as every later one.
    pwm_prescaler #(
        .div_width (div_width)
    ) u_prescaler (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .En       (En && running_q),
        .prescale (prescale),
        .tick     (tick)
    );

    // Sequencer, index counter, PWM counter and comparator next-state logic
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        table_addr_d = table_addr_q;
        next_duty_d  = next_duty_q;
        duty_d       = duty_q;
        pwm_cnt_d    = pwm_cnt_q;
        running_d    = running_q;
        strobe_d     = 1'b0;
        wrap_d       = 1'b0;
        pwm_out_d    = 1'b0;
        do_load      = 1'b0;
        period_end   = tick && (pwm_cnt_q == PWM_MAX);
        idx_nxt      = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

        if (!En) begin
            state_d      = ST_IDLE;
            idx_d        = '0;
            table_addr_d = '0;
            next_duty_d  = '0;
            pwm_cnt_d    = '0;
            running_d    = 1'b0;
        end else begin
            if (running_q && tick) begin
                pwm_cnt_d = pwm_cnt_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    table_addr_d = idx_q;
                    state_d      = ST_FETCH;
                end
                ST_FETCH: begin
                    state_d = ST_CAPT;
                end
                ST_CAPT: begin
                    next_duty_d = table_data;
                    state_d     = running_q ? ST_WAIT : ST_LOAD;
                end
                ST_LOAD: begin
                    do_load = 1'b1;
                end
                ST_WAIT: begin
                    do_load = period_end;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // A load replaces the PWM counter wrap, so no tick is lost
            if (do_load) begin
                duty_d       = next_duty_q;
                pwm_cnt_d    = '0;
                strobe_d     = 1'b1;
                wrap_d       = (idx_q == '0);
                idx_d        = idx_nxt;
                table_addr_d = idx_nxt;
                running_d    = 1'b1;
                state_d      = ST_FETCH;
            end

            pwm_out_d = running_d && (pwm_cnt_d < duty_d);
        end
    end

    // State and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            table_addr_q <= '0;
            next_duty_q  <= '0;
            duty_q       <= '0;
            pwm_cnt_q    <= '0;
            running_q    <= 1'b0;
            pwm_out_q    <= 1'b0;
            strobe_q     <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            table_addr_q <= table_addr_d;
            next_duty_q  <= next_duty_d;
            duty_q       <= duty_d;
            pwm_cnt_q    <= pwm_cnt_d;
            running_q    <= running_d;
            pwm_out_q    <= pwm_out_d;
            strobe_q     <= strobe_d;
            wrap_q       <= wrap_d;
        end
    end

    assign table_addr    = table_addr_q;
    assign table_wr      = 1'b0;
    assign pwm_out       = pwm_out_q;
    assign duty          = duty_q;
    assign sample_strobe = strobe_q;
    assign wrap          = wrap_q;

endmodule : table_pwm_player

// File: tb/tb_table_pwm_player.sv
// Bench for table_pwm_player: a 4-entry table build and a 1-entry table
// build, each fed by a registered-read table model. Expected duties,
// wrap pulses, period lengths and high-time counts come from a
// sample-sequence model: sample k plays mem[k % len] for 256*(prescale+1)
// clocks with duty*(prescale+1) clocks high.
module tb_table_pwm_player;
    import tpp_pkg::*;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 7;
    localparam int unsigned TLEN = 4;
    localparam int unsigned DIVW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            en1;
    logic [DIVW-1:0] prescale;

    logic [AW-1:0] taddr, taddr1;
    logic          twr, twr1;
    logic [DW-1:0] tdata, tdata1;
    logic          pwm_out, pwm_out1;
    logic [DW-1:0] duty, duty1;
    logic          sample_strobe, strobe1;
    logic          wrap, wrap1;

    logic [DW-1:0] mem [TLEN];
    localparam logic [DW-1:0] SINGLE_VAL = 8'd77;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    table_pwm_player #(
        .data_width (DW),
        .addr_width (AW),
        .table_len  (TLEN),
        .div_width  (DIVW)
    ) dut (
        .Clk           (clk),
        .Rst_n         (rst_n),
        .En            (en),
        .prescale      (prescale),
        .table_addr    (taddr),
        .table_wr      (twr),
        .table_data    (tdata),
        .pwm_out       (pwm_out),
        .duty          (duty),
        .sample_strobe (sample_strobe),
        .wrap          (wrap)
    );

    table_pwm_player #(
        .data_width (DW),
        .addr_width (AW),
        .table_len  (1),
        .div_width  (DIVW)
    ) dut1 (
        .Clk           (clk),
        .Rst_n         (rst_n),
        .En            (en1),
        .prescale      (prescale),
        .table_addr    (taddr1),
        .table_wr      (twr1),
        .table_data    (tdata1),
        .pwm_out       (pwm_out1),
        .duty          (duty1),
        .sample_strobe (strobe1),
        .wrap          (wrap1)
    );

    // Signal-table models: synchronous read, one clock latency
    always_ff @(posedge clk) begin
        tdata  <= (taddr < AW'(TLEN)) ? mem[taddr[1:0]] : 8'hA5;
        tdata1 <= (taddr1 == '0) ? SINGLE_VAL : 8'h5A;
    end

    typedef struct {
        int unsigned   p;
        logic [DW-1:0] t0, t1, t2, t3;
        int unsigned   exp_period;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_duty(input int k);
        return int'(mem[k % TLEN]);
    endfunction

    task automatic wait_strobe(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_strobe && n < budget);
    endtask

    // Enable playback and check nstr consecutive sample periods
    task automatic run_config(input int unsigned p, input int unsigned exp_period,
                              input int nstr, input string tag);
        int n;
        int len;
        int hi;
        prescale = DIVW'(p);
        @(negedge clk);
        en = 1'b1;
        wait_strobe(8, n);
        check({tag, "_start_latency"}, n, 4);
        for (int k = 0; k < nstr; k++) begin
            check({tag, "_duty"}, duty, ref_duty(k));
            check({tag, "_wrap"}, wrap, (k % TLEN) == 0);
            len = 0;
            hi  = 0;
            do begin
                hi += int'(pwm_out);
                len++;
                @(negedge clk);
            end while (!sample_strobe && len < int'(exp_period) + 16);
            check({tag, "_period"}, len, exp_period);
            check({tag, "_high"}, hi, ref_duty(k) * int'(p + 1));
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int len;
        int hi;
        int unsigned p;
        int unsigned d;

        vecs[0] = '{p: 0, t0: 8'd0,   t1: 8'd2,   t2: 8'd4,  t3: 8'd6,   exp_period: 256};
        vecs[1] = '{p: 3, t0: 8'd0,   t1: 8'd2,   t2: 8'd4,  t3: 8'd6,   exp_period: 1024};
        vecs[2] = '{p: 0, t0: 8'd0,   t1: 8'd255, t2: 8'd9,  t3: 8'd128, exp_period: 256};
        vecs[3] = '{p: 1, t0: 8'd200, t1: 8'd1,   t2: 8'd0,  t3: 8'd255, exp_period: 512};

        for (int i = 0; i < int'(TLEN); i++) mem[i] = 8'(i * 2);

        rst_n    = 1'b0;
        en       = 1'b0;
        en1      = 1'b0;
        prescale = '0;
        repeat (3) @(negedge clk);
        check("reset_addr", taddr, 0);
        check("reset_duty", duty, 0);
        check("reset_pwm", pwm_out, 0);
        check("reset_strobe", sample_strobe, 0);
        check("reset_wrap", wrap, 0);
        check("reset_wr", twr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of playback
        en = 1'b1;
        wait_strobe(8, n);
        wait_strobe(300, n);
        check("midrst_pre_duty", duty, 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_addr", taddr, 0);
        check("midrst_duty", duty, 0);
        check("midrst_pwm", pwm_out, 0);
        check("midrst_strobe", sample_strobe, 0);
        check("midrst_wrap", wrap, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_state_idle", dut.state_q == ST_IDLE, 1);
        check("midrst_addr_after", taddr, 0);

        // Table-driven configurations
        for (int v = 0; v < 4; v++) begin
            mem[0] = vecs[v].t0;
            mem[1] = vecs[v].t1;
            mem[2] = vecs[v].t2;
            mem[3] = vecs[v].t3;
            run_config(vecs[v].p, vecs[v].exp_period, 5, "vec");
        end

        // Prescale lowered 3 -> 0 mid-period
        for (int i = 0; i < int'(TLEN); i++) mem[i] = 8'(i * 2);
        prescale = 16'd3;
        en = 1'b1;
        wait_strobe(8, n);
        repeat (301) @(negedge clk);
        prescale = 16'd0;
        #1;
        check("presc_drop_tick", dut.tick, 1);
        @(negedge clk);
        wait_strobe(400, n);
        check("presc_drop_no_lockup", sample_strobe, 1);
        check("presc_drop_duty", duty, 2);
        en = 1'b0;
        @(negedge clk);

        // Stop during WAIT while pwm_out is high, then restart
        mem[0] = 8'd10; mem[1] = 8'd200; mem[2] = 8'd30; mem[3] = 8'd40;
        prescale = '0;
        en = 1'b1;
        wait_strobe(8, n);
        wait_strobe(300, n);
        repeat (50) @(negedge clk);
        check("stop_pre_high", pwm_out, 1);
        en = 1'b0;
        @(negedge clk);
        check("stop_pwm_low", pwm_out, 0);
        check("stop_addr", taddr, 0);
        check("stop_duty_held", duty, 200);
        check("stop_state_idle", dut.state_q == ST_IDLE, 1);
        run_config(0, 256, 2, "restart");

        // Single-entry table build
        prescale = '0;
        en1 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!strobe1 && n < 8);
        check("t1_start_latency", n, 4);
        for (int k = 0; k < 3; k++) begin
            check("t1_duty", duty1, SINGLE_VAL);
            check("t1_wrap", wrap1, 1);
            check("t1_addr", taddr1, 0);
            len = 0;
            hi  = 0;
            do begin
                hi += int'(pwm_out1);
                len++;
                @(negedge clk);
            end while (!strobe1 && len < 272);
            check("t1_period", len, 256);
            check("t1_high", hi, SINGLE_VAL);
        end
        en1 = 1'b0;
        @(negedge clk);

        // Randomized tables, prescale and stop points
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < int'(TLEN); i++) mem[i] = 8'($urandom_range(0, 255));
            p = $urandom_range(0, 2);
            run_config(p, 256 * (p + 1), 5, "rand");
            en = 1'b1;
            wait_strobe(8, n);
            d = $urandom_range(3, 200);
            repeat (d) @(negedge clk);
            en = 1'b0;
            @(negedge clk);
            check("rand_stop_pwm", pwm_out, 0);
            check("rand_stop_addr", taddr, 0);
            check("rand_stop_duty", duty, mem[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_table_pwm_player
